bin2res_mod7_serial: RTL and testbench

Bit-serial forward converter from a 32-bit unsigned binary operand to its residue modulo 7 in the RNS front end.
- Each cycle it drives one bit index into an instantiated mod7_LUT and takes back the weight 2^idx mod 7.
- If the operand bit at idx is set, it adds that weight to a 3-bit modular accumulator.
- The result is delivered on a valid/ready output. It is the direct consumer of mod7_LUT and feeds the mod-7 residue channel.

---
 rtl/bin2res_mod7_serial.sv | 163 ++++++++++++++++
 tb/tb_bin2res_mod7_serial.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2res_mod7_serial.sv
// Bit-serial binary-to-residue converter (mod 7) for the RNS front end.
// One operand bit per cycle is weighted by 2^idx mod 7 (from mod7_LUT)
// and folded into a 3-bit modular accumulator; the residue is returned
// on a valid/ready output.

// Weight table: 2^n mod 7 repeats 1, 2, 4 with period 3.
module mod7_LUT (
  input  logic [5:0] n,
  output logic [2:0] out
);

  logic [5:0] phase_s;

  // Reduce the exponent mod 3 and select the matching power of two.
  always_comb begin
    phase_s = n % 6'd3;
    case (phase_s)
      6'd0:    out = 3'd1;
      6'd1:    out = 3'd2;
      6'd2:    out = 3'd4;
      default: out = 3'd1;
    endcase
  end

endmodule

module bin2res_mod7_serial #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_res,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_BITS - 1);

  state_t            state_q, state_d;
  logic [2:0]        acc_q, acc_d;
  logic [4:0]        idx_q, idx_d;
  logic [N_BITS-1:0] opnd_q, opnd_d;
  logic              out_valid_q, out_valid_d;
  logic [2:0]        out_res_q, out_res_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;

  logic [2:0]        weight_s;
  logic [3:0]        sum_s;
  logic [3:0]        sum_m7_s;
  logic [2:0]        acc_add_s;

  // Weight for the bit currently being processed.
  mod7_LUT u_lut (
    .n   ({1'b0, idx_q}),
    .out (weight_s)
  );

  // Modular add: acc + w is at most 6 + 4 = 10, so one conditional subtract suffices.
  always_comb begin
    sum_s    = {1'b0, acc_q} + {1'b0, weight_s};
    sum_m7_s = sum_s - 4'd7;
    if (sum_s >= 4'd7) begin
      acc_add_s = sum_m7_s[2:0];
    end else begin
      acc_add_s = sum_s[2:0];
    end
  end

  // Next-state logic for the IDLE -> BUSY -> DONE sequence and the datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    opnd_d  = opnd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opnd_d  = in_data;
          acc_d   = 3'd0;
          idx_d   = 5'd0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (opnd_q[idx_q]) begin
          acc_d = acc_add_s;
        end else begin
          acc_d = acc_q;
        end
        idx_d = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags are decoded from the next state so they leave the block registered.
  always_comb begin
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_BUSY);
    in_ready_d  = (state_d == S_IDLE);
    if (state_d == S_DONE) begin
      out_res_d = acc_d;
    end else begin
      out_res_d = 3'd0;
    end
  end

  // State and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= 3'd0;
      idx_q       <= 5'd0;
      opnd_q      <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= 3'd0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      opnd_q      <= opnd_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_bin2res_mod7_serial.sv
// Self-checking bench for bin2res_mod7_serial: table-driven vectors,
// a scoreboard queue filled at drive time and drained by an output monitor,
// plus hand-written backpressure, isolation, reset and back-to-back sequences.
module tb_bin2res_mod7_serial;

  localparam int N_BITS = 32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_res;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_edge = 0;
  logic ov_prev = 1'b0;

  logic [2:0] sb[$];
  int         dq[$];

  typedef struct {
    logic [31:0] data;
    logic [2:0]  exp;
  } vec_t;

  vec_t tbl[5];

  bin2res_mod7_serial #(.N_BITS(N_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [31:0] d);
    return 3'(d % 32'd7);
  endfunction

  // Output monitor: records accepts, checks latency and pops the scoreboard on delivery.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_edge = cyc + 1;
      if (out_valid && !ov_prev) chk("latency", 32'(cyc - acc_edge), 32'(N_BITS));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_result: got out_res=%0d with nothing expected", out_res);
        end else begin
          chk("result", 32'(out_res), 32'(sb.pop_front()));
        end
        dq.push_back(cyc + 1);
      end
    end
    ov_prev = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] e);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(sb.size() == 0 && in_ready) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(sb.size() == 0 && in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'd7,          3'd0};
    tbl[1] = '{32'd100,        3'd2};
    tbl[2] = '{32'd12345,      3'd4};
    tbl[3] = '{32'h8000_0000,  3'd2};
    tbl[4] = '{32'hFFFF_FFFF,  3'd3};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);

    // Zero operand: in_ready low and busy high through all BUSY cycles.
    begin
      int ir_hi = 0;
      int bz_lo = 0;
      send(32'd0, 3'd0);
      for (int i = 0; i < N_BITS; i++) begin
        if (in_ready) ir_hi++;
        if (!busy) bz_lo++;
        tick();
      end
      chk("busy_in_ready_low", 32'(ir_hi), 32'd0);
      chk("busy_high", 32'(bz_lo), 32'd0);
      chk("done_out_valid", 32'(out_valid), 32'd1);
      chk("done_in_ready", 32'(in_ready), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      drain();
    end

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, tbl[i].exp);
      drain();
    end

    // Backpressure: result must hold while out_ready is low.
    begin
      int n = 0;
      int errs = 0;
      out_ready = 1'b0;
      send(32'd10, 3'd3);
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 20; i++) begin
        if (out_res !== 3'd3 || in_ready !== 1'b0 || out_valid !== 1'b1) errs++;
        tick();
      end
      chk("bp_hold", 32'(errs), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_busy", 32'(busy), 32'd0);
      drain();
    end

    // Operand isolation: input noise during BUSY must not disturb the result.
    send(32'h1234_5678, model(32'h1234_5678));
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Reset in BUSY cycle 10 aborts the operand.
    send(32'hDEAD_BEEF, model(32'hDEAD_BEEF));
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send(32'd21, 3'd0);
    drain();

    // Back-to-back with in_valid held high.
    dq.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      int n = 0;
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      in_data = 32'(v);
      sb.push_back(3'(v));
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", 32'(dq.size()), 32'd3);
    if (dq.size() >= 3) begin
      chk("b2b_spacing_1", 32'(dq[1] - dq[0]), 32'(N_BITS + 2));
      chk("b2b_spacing_2", 32'(dq[2] - dq[1]), 32'(N_BITS + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
